// File: rtl/scalar_mult_ctrl.sv
// -----------------------------------------------------------------------------
// scalar_mult_ctrl
//   Sequencer for right-to-left double-and-add scalar multiplication.
//   For each of KEY_BITS scalar bits (LSB first) it requests the bit from the
//   key shifter, optionally launches an ADD (R <= R + P), then always launches
//   a DOUBLE (P <= 2P) on the point ALU. Runs are started by the top-level
//   ECC sequencer and end with a one-cycle o_done pulse.
//
//   Optional feature macro: ECC_CONST_TIME_EN
//     defined     : a zero bit still runs the ADD with o_op_dummy=1 so every bit
//                   takes the same number of cycles.
//     not defined : a zero bit skips the ADD; o_op_dummy is always 0.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      start a run (sampled in IDLE only)
//   o_busy       high whenever not IDLE
//   o_done       one-cycle run-complete pulse
//   o_bit_req    one-cycle key-bit request to the shifter
//   i_bit_ack    shifter acknowledge, i_bit valid in this cycle
//   i_bit        scalar bit from shifter
//   o_op_start   one-cycle point-op launch
//   o_op_sel     0 = DOUBLE, 1 = ADD; stable until i_op_done
//   o_op_dummy   ADD result to be discarded by the ALU
//   i_op_done    point op finished (ignored in the launch cycle)
//   o_bit_cnt    number of bits fully processed in the current run
//
// State table
//   S_IDLE     | waiting for i_start
//   S_REQ      | pulse o_bit_req
//   S_WAIT_BIT | waiting for shifter ack, latch the bit
//   S_ADD_GO   | launch ADD
//   S_ADD_WAIT | waiting for ADD completion
//   S_DBL_GO   | launch DOUBLE
//   S_DBL_WAIT | waiting for DOUBLE completion
//   S_NEXT     | bump bit counter, decide next bit or finish
//   S_FIN      | pulse o_done
// -----------------------------------------------------------------------------
module scalar_mult_ctrl #(
    parameter int KEY_BITS = 32,
    parameter int CNT_W    = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_bit_req,
    input  logic             i_bit_ack,
    input  logic             i_bit,
    output logic             o_op_start,
    output logic             o_op_sel,
    output logic             o_op_dummy,
    input  logic             i_op_done,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_WAIT_BIT = 4'd2;
    localparam logic [3:0] S_ADD_GO   = 4'd3;
    localparam logic [3:0] S_ADD_WAIT = 4'd4;
    localparam logic [3:0] S_DBL_GO   = 4'd5;
    localparam logic [3:0] S_DBL_WAIT = 4'd6;
    localparam logic [3:0] S_NEXT     = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

`ifdef ECC_CONST_TIME_EN
    localparam logic CT_EN = 1'b1;
`else
    localparam logic CT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_BITS);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             in_add;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            // An ack coinciding with the request cannot belong to it; ignore.
            S_REQ: state_d = S_WAIT_BIT;
            S_WAIT_BIT: begin
                if (i_bit_ack) begin
                    bit_d = i_bit;
                    if (i_bit || CT_EN) begin
                        state_d = S_ADD_GO;
                    end else begin
                        state_d = S_DBL_GO;
                    end
                end
            end
            S_ADD_GO: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (i_op_done) begin
                    state_d = S_DBL_GO;
                end
            end
            S_DBL_GO: state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (i_op_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == LAST_CNT) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // All outputs decode the registered state, so they are glitch-free and
    // drop to zero as soon as reset is asserted.
    assign in_add     = (state_q == S_ADD_GO) || (state_q == S_ADD_WAIT);
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_FIN);
    assign o_bit_req  = (state_q == S_REQ);
    assign o_op_start = (state_q == S_ADD_GO) || (state_q == S_DBL_GO);
    assign o_op_sel   = in_add;
    // With constant-time off CT_EN folds this to zero.
    assign o_op_dummy = CT_EN & in_add & ~bit_q;
    assign o_bit_cnt  = cnt_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
module tb_scalar_mult_ctrl;

    localparam int KB = 32;
    localparam int CW = 6;
`ifdef ECC_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, bit_req, op_start, op_sel, op_dummy;
    logic          bit_ack = 1'b0;
    logic          bit_in = 1'b0;
    logic          op_done = 1'b0;
    logic [CW-1:0] bit_cnt;

    scalar_mult_ctrl #(.KEY_BITS(KB), .CNT_W(CW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_bit_req  (bit_req),
        .i_bit_ack  (bit_ack),
        .i_bit      (bit_in),
        .o_op_start (op_start),
        .o_op_sel   (op_sel),
        .o_op_dummy (op_dummy),
        .i_op_done  (op_done),
        .o_bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {bit sel; bit dummy;} op_t;
    op_t exp_q[$];
    op_t e;

    // Cycle numbering: the cycle following the edge that samples i_start is cycle 1.
    int cyc;
    bit in_run;
    bit done_seen;
    int done_cyc;
    int exp_done_cyc;
    int bits_acked;
    int n_add, n_dbl, n_dummy;
    bit op_pend;
    bit pend_sel, pend_dummy;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process, samples mid-cycle.
    always @(negedge clk) begin
        if (!rst && in_run && !done_seen) begin
            check("busy_in_run", busy, 1);
            if (op_start) begin
                check("op_start_unexpected", (exp_q.size() > 0), 1);
                check("op_overlap", op_pend, 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("op_sel", op_sel, e.sel);
                    check("op_dummy", op_dummy, e.dummy);
                    pend_sel   = e.sel;
                    pend_dummy = e.dummy;
                end
                n_add   += op_sel ? 1 : 0;
                n_dbl   += op_sel ? 0 : 1;
                n_dummy += op_dummy ? 1 : 0;
                op_pend = 1'b1;
            end else if (op_pend) begin
                check("op_sel_stable", op_sel, pend_sel);
                check("op_dummy_stable", op_dummy, pend_dummy);
                if (op_done) op_pend = 1'b0;
            end
            if (bit_req) begin
                check("bit_cnt_at_req", bit_cnt, bits_acked);
                check("req_while_op", op_pend, 0);
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("done_cycle", cyc, exp_done_cyc);
                check("bit_cnt_at_done", bit_cnt, KB);
                check("ops_left_at_done", exp_q.size(), 0);
                check("op_pending_at_done", op_pend, 0);
            end
        end
    end

    task automatic idle_inputs();
        start   = 1'b0;
        bit_ack = 1'b0;
        op_done = 1'b0;
        bit_in  = 1'b0;
    endtask

    // Drives one run with the bench acting as key shifter and point ALU.
    task automatic run(input logic [31:0] key, input int ack_dly, input int op_dly,
                       input bit abuse, input bit abort);
        int sum, bit_idx, ack_cd, done_cd, per;
        bit real_add;
        exp_q.delete();
        sum = 0;
        for (int i = 0; i < KB; i++) begin
            real_add = key[i] | CT;
            if (real_add) exp_q.push_back('{sel: 1'b1, dummy: ~key[i]});
            exp_q.push_back('{sel: 1'b0, dummy: 1'b0});
            // REQ + ack wait + DOUBLE launch/wait + NEXT, plus ADD launch/wait
            per = 1 + ack_dly + 1 + op_dly + 1 + (real_add ? 1 + op_dly : 0);
            sum += per;
        end
        exp_done_cyc = sum + 1;
        bit_idx = 0; ack_cd = 0; done_cd = 0;
        bits_acked = 0; n_add = 0; n_dbl = 0; n_dummy = 0;
        op_pend = 0; done_seen = 0; done_cyc = -1;

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        in_run = 1'b1;
        while (!done_seen && cyc < 3000) begin
            bit_ack = 1'b0;
            op_done = 1'b0;
            start   = 1'b0;
            if (ack_cd == 1) begin
                bit_ack = 1'b1;
                bit_in  = key[bit_idx];
                bit_idx++;
                bits_acked++;
            end
            if (ack_cd > 0) ack_cd--;
            if (done_cd == 1) op_done = 1'b1;
            if (done_cd > 0) done_cd--;
            if (bit_req) begin
                ack_cd = ack_dly;
                if (abuse) begin
                    bit_ack = 1'b1;
                    bit_in  = ~key[bit_idx];
                end
            end
            if (op_start) begin
                done_cd = op_dly;
                if (abuse) op_done = 1'b1;
            end
            if (abuse && (cyc % 7 == 3)) start = 1'b1;
            if (abort && op_sel && !op_start) begin
                in_run = 1'b0;
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_req", bit_req, 0);
                check("rst_op_start", op_start, 0);
                check("rst_op_sel", op_sel, 0);
                check("rst_op_dummy", op_dummy, 0);
                check("rst_bit_cnt", bit_cnt, 0);
                idle_inputs();
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                end
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("after_rst_idle", busy, 0);
                end
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        in_run = 1'b0;
        if (!done_seen) check("timeout_no_done", 0, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_bit_cnt_hold", bit_cnt, KB);
        check("bits_consumed", bit_idx, KB);
    endtask

    initial begin
        in_run = 0;
        done_seen = 0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_req", bit_req, 0);
        check("reset_op_start", op_start, 0);
        check("reset_op_sel", op_sel, 0);
        check("reset_op_dummy", op_dummy, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero key, ideal responders.
        run(32'h0000_0000, 1, 1, 0, 0);
        check("zeros_done_cyc", done_cyc, CT ? 225 : 161);
        check("zeros_n_add", n_add, CT ? 32 : 0);
        check("zeros_n_dbl", n_dbl, 32);

        // All-ones key: alternating ADD/DOUBLE.
        run(32'hFFFF_FFFF, 1, 1, 0, 0);
        check("ones_done_cyc", done_cyc, 225);
        check("ones_n_add", n_add, 32);
        check("ones_n_dbl", n_dbl, 32);
        check("ones_n_dummy", n_dummy, 0);

        // Key 5: ADDs at bits 0 and 2.
        run(32'h0000_0005, 1, 1, 0, 0);
        check("key5_done_cyc", done_cyc, CT ? 225 : 165);
        check("key5_n_add", n_add, CT ? 32 : 2);
        check("key5_n_dummy", n_dummy, CT ? 30 : 0);
        check("key5_n_dbl", n_dbl, 32);

        // Reset in the middle of an ADD wait, then a clean run.
        run(32'hFFFF_FFFF, 1, 1, 0, 1);
        run(32'hA5C3_0F01, 1, 1, 0, 0);

        // Protocol abuse with a 5-cycle ack delay; result must match key 5.
        run(32'h0000_0005, 5, 1, 1, 0);
        check("abuse_n_add", n_add, CT ? 32 : 2);
        check("abuse_n_dbl", n_dbl, 32);
        check("abuse_done_cyc", done_cyc, CT ? 353 : 293);

        // Slower ALU.
        run(32'h8000_0001, 1, 3, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
